// File: rtl/nois_led_sequencer.sv
// LED pattern sequencer: CPU-programmed pattern/period/mode on an Avalon-MM slave,
// stepped on a programmable tick and pushed to the LED PIO data register via an Avalon-MM master.
module nois_led_sequencer #(
  parameter int LED_WIDTH = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                 r_enable;
  logic [1:0]           r_mode;
  logic [DIV_WIDTH-1:0] r_period;
  logic [DIV_WIDTH-1:0] r_tick_cnt;
  logic [LED_WIDTH-1:0] r_pattern;
  logic                 r_dir;
  logic [7:0]           r_count;
  logic                 r_pending;
  logic                 r_overrun;
  logic [31:0]          r_wdata;

  logic                 w_csr_wr;
  logic                 w_ctrl_wr;
  logic                 w_period_wr;
  logic                 w_pat_wr;
  logic                 w_run;
  logic [DIV_WIDTH-1:0] w_max;
  logic                 w_tick;
  logic                 w_step;
  logic                 w_consume;
  logic                 w_busy;
  logic [LED_WIDTH-1:0] w_next_pat;
  logic                 w_next_dir;
  logic [31:0]          w_status;

  assign w_csr_wr    = chipselect & ~write_n;
  assign w_ctrl_wr   = w_csr_wr & (address == 2'd0);
  assign w_period_wr = w_csr_wr & (address == 2'd1);
  assign w_pat_wr    = w_csr_wr & (address == 2'd2);

  assign w_run  = r_enable & (r_mode != 2'd0);
  assign w_max  = (r_period == '0) ? DIV_WIDTH'(1) : r_period;
  // >= rather than == so a PERIOD shrunk below the running count still wraps promptly
  assign w_tick = w_run & (r_tick_cnt >= (w_max - DIV_WIDTH'(1)));
  assign w_step = w_tick & ~w_pat_wr;

  assign w_busy    = (r_state == S_WRITE);
  assign w_consume = (r_state == S_IDLE) & r_pending;

  always_comb begin
    w_next_pat = r_pattern;
    w_next_dir = r_dir;
    case (r_mode)
      2'd1: w_next_pat = {r_pattern[LED_WIDTH-2:0], r_pattern[LED_WIDTH-1]};
      2'd2: begin
        if (!r_dir && r_pattern[LED_WIDTH-1]) begin
          w_next_dir = 1'b1;
          w_next_pat = r_pattern >> 1;
        end else if (r_dir && r_pattern[0]) begin
          w_next_dir = 1'b0;
          w_next_pat = r_pattern << 1;
        end else if (r_dir) begin
          w_next_pat = r_pattern >> 1;
        end else begin
          w_next_pat = r_pattern << 1;
        end
      end
      2'd3: w_next_pat = r_pattern + LED_WIDTH'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_mode     <= 2'd0;
      r_period   <= '0;
      r_tick_cnt <= '0;
      r_pattern  <= '0;
      r_dir      <= 1'b0;
      r_count    <= '0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_wdata    <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= writedata[0];
        r_mode   <= writedata[2:1];
      end
      if (w_period_wr) r_period <= writedata[DIV_WIDTH-1:0];

      if (w_ctrl_wr || !w_run || w_tick) r_tick_cnt <= '0;
      else                               r_tick_cnt <= r_tick_cnt + DIV_WIDTH'(1);

      if (w_pat_wr) begin
        r_pattern <= writedata[LED_WIDTH-1:0];
      end else if (w_step) begin
        r_pattern <= w_next_pat;
        r_dir     <= w_next_dir;
        r_count   <= r_count + 8'd1;
      end

      // A new request in the same cycle the FSM consumes the old one must survive
      if (w_pat_wr || w_step) r_pending <= 1'b1;
      else if (w_consume)     r_pending <= 1'b0;

      if (w_ctrl_wr)                  r_overrun <= 1'b0;
      else if (w_step && r_pending)   r_overrun <= 1'b1;

      if (w_consume) r_wdata <= 32'(r_pattern);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_pending) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        if (!m_waitrequest) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign m_address   = 2'd0;
  assign m_writedata = r_wdata;

  always_comb begin
    w_status                  = '0;
    w_status[LED_WIDTH-1:0]   = r_pattern;
    w_status[8]               = w_busy;
    w_status[9]               = r_overrun;
    w_status[23:16]           = r_count;
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = {29'd0, r_mode, r_enable};
        2'd1:    readdata = 32'(r_period);
        2'd2:    readdata = 32'(r_pattern);
        default: readdata = w_status;
      endcase
    end
  end

endmodule
